// File: rtl/jp_responder_if.sv
// Console-side joypad port bundle: button state in, latch/clk polling in, serial data out.
interface jp_responder_if;
  logic [7:0] btn_in;
  logic [1:0] turbo_en_in;
  logic       jp_latch_in;
  logic       jp_clk_in;
  logic       jp_data_out;
  logic       poll_strobe_out;
  logic [3:0] shift_cnt_out;

  modport master (
    output btn_in, turbo_en_in, jp_latch_in, jp_clk_in,
    input  jp_data_out, poll_strobe_out, shift_cnt_out
  );

  modport slave (
    input  btn_in, turbo_en_in, jp_latch_in, jp_clk_in,
    output jp_data_out, poll_strobe_out, shift_cnt_out
  );
endinterface

// File: rtl/jp_responder.sv
// NES controller emulation: answers latch/clk polling with 8 serial button bits.
// Latch and clk each pass through a synchroniser plus glitch filter before the FSM sees them.

module jp_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk_in,
  input  logic nrst_in,
  input  logic pin,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   cand, acc, acc_prev;
  logic [CW-1:0]          run_q, run_d;

  // run_d counts consecutive cycles the synced level has held, including this one
  always_comb begin
    run_d = CW'(1);
    if (sync[SYNC_STAGES-1] == cand)
      run_d = (run_q == CW'(FILTER_CYCLES)) ? run_q : run_q + CW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (!nrst_in) begin
      sync     <= '0;
      cand     <= 1'b0;
      run_q    <= '0;
      acc      <= 1'b0;
      acc_prev <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], pin};
      cand     <= sync[SYNC_STAGES-1];
      run_q    <= run_d;
      if (run_d == CW'(FILTER_CYCLES)) acc <= sync[SYNC_STAGES-1];
      acc_prev <= acc;
    end
  end

  assign rise = acc & ~acc_prev;
  assign fall = ~acc & acc_prev;
endmodule

module jp_responder #(
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_CYCLES   = 4,
  parameter int TURBO_DIV       = 2,
  parameter int DATA_ACTIVE_LOW = 1
) (
  input  logic           clk_in,
  input  logic           nrst_in,
  jp_responder_if.slave  jp
);
  localparam int   TW  = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  localparam logic DAL = 1'(DATA_ACTIVE_LOW);

  typedef enum logic {LOAD, SHIFT} state_t;

  // lane 0 = latch, lane 1 = shift clock
  logic [1:0] pins, rise, fall;
  assign pins = {jp.jp_clk_in, jp.jp_latch_in};

  jp_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_flt [1:0] (
    .clk_in (clk_in),
    .nrst_in(nrst_in),
    .pin    (pins),
    .rise   (rise),
    .fall   (fall)
  );

  state_t        state;
  logic [7:0]    shift_reg, shift_nxt, eff_btn;
  logic [3:0]    shift_cnt;
  logic [TW-1:0] turbo_cnt;
  logic          turbo_phase, data_q, strobe_q;

  always_comb begin
    eff_btn    = jp.btn_in;
    eff_btn[0] = jp.btn_in[0] & (~jp.turbo_en_in[0] | turbo_phase);
    eff_btn[1] = jp.btn_in[1] & (~jp.turbo_en_in[1] | turbo_phase);
  end

  // Next shift register value; the data pin is registered from this so edge latency stays fixed
  always_comb begin
    shift_nxt = shift_reg;
    case (state)
      SHIFT: begin
        if (rise[0])      shift_nxt = eff_btn;
        else if (rise[1]) shift_nxt = {1'b1, shift_reg[7:1]};
      end
      LOAD: if (!fall[0]) shift_nxt = eff_btn;
      default: shift_nxt = shift_reg;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!nrst_in) begin
      state       <= SHIFT;
      shift_reg   <= '0;
      shift_cnt   <= '0;
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
      strobe_q    <= 1'b0;
      data_q      <= DAL;
    end else begin
      shift_reg <= shift_nxt;
      data_q    <= shift_nxt[0] ^ DAL;
      strobe_q  <= 1'b0;
      case (state)
        SHIFT: begin
          // latch rise beats a coincident clk rise
          if (rise[0]) begin
            state     <= LOAD;
            shift_cnt <= '0;
          end else if (rise[1] && shift_cnt != 4'd8) begin
            shift_cnt <= shift_cnt + 4'd1;
          end
        end
        LOAD: begin
          shift_cnt <= '0;
          if (fall[0]) begin
            state    <= SHIFT;
            strobe_q <= 1'b1;
            if (turbo_cnt == TW'(TURBO_DIV - 1)) begin
              turbo_cnt   <= '0;
              turbo_phase <= ~turbo_phase;
            end else begin
              turbo_cnt <= turbo_cnt + TW'(1);
            end
          end
        end
        default: state <= SHIFT;
      endcase
    end
  end

  assign jp.jp_data_out     = data_q;
  assign jp.poll_strobe_out = strobe_q;
  assign jp.shift_cnt_out   = shift_cnt;
endmodule

// File: tb/tb_jp_responder.sv
// Drives console-style latch/clk polling and checks the serial report against a poll-level model.
module tb_jp_responder;
  localparam int S = 2, F = 4, TD = 2, DAL = 1, GAP = 12;

  logic clk_in = 1'b0, nrst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  jp_responder_if jp();

  jp_responder #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .TURBO_DIV(TD), .DATA_ACTIVE_LOW(DAL)) dut (
    .clk_in (clk_in),
    .nrst_in(nrst_in),
    .jp     (jp.slave)
  );

  int checks = 0, failures = 0, strobes = 0, polls = 0;

  always @(negedge clk_in) if (jp.poll_strobe_out === 1'b1) strobes++;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Report for the n-th poll since reset: turbo phase flips every TD polls, starting masked.
  function automatic logic [7:0] report(logic [7:0] b, logic [1:0] te, int n);
    logic ph;
    ph = ((n / TD) % 2) == 1;
    report = b;
    if (te[0] && !ph) report[0] = 1'b0;
    if (te[1] && !ph) report[1] = 1'b0;
  endfunction

  function automatic logic pin_at(logic [7:0] r, int k);
    logic lg;
    lg = (k < 8) ? r[k] : 1'b1;
    pin_at = lg ^ 1'(DAL);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic latch_pulse(int w);
    tick(1); jp.jp_latch_in = 1'b1;
    tick(w); jp.jp_latch_in = 1'b0;
    tick(GAP); @(negedge clk_in);
  endtask

  task automatic clk_pulse(int w);
    tick(1); jp.jp_clk_in = 1'b1;
    tick(w); jp.jp_clk_in = 1'b0;
    tick(GAP); @(negedge clk_in);
  endtask

  task automatic apply_reset(int n);
    tick(1); nrst_in = 1'b0;
    tick(n); @(negedge clk_in);
    chk("rst_data", 8'(jp.jp_data_out), 8'd1);
    chk("rst_cnt", 8'(jp.shift_cnt_out), 8'd0);
    chk("rst_strobe", 8'(jp.poll_strobe_out), 8'd0);
    tick(1); nrst_in = 1'b1;
    polls = 0;
    tick(GAP);
  endtask

  task automatic do_poll(logic [7:0] b, logic [1:0] te, int w, output logic [7:0] r);
    int s0;
    jp.btn_in = b; jp.turbo_en_in = te;
    s0 = strobes;
    latch_pulse(w);
    r = report(b, te, polls);
    polls++;
    chk("poll_strobe", 8'(strobes - s0), 8'd1);
    chk("poll_cnt", 8'(jp.shift_cnt_out), 8'd0);
    chk("poll_bit0", 8'(jp.jp_data_out), 8'(pin_at(r, 0)));
  endtask

  task automatic read_bits(logic [7:0] r, int k0, int k1, bit rnd);
    for (int k = k0; k <= k1; k++) begin
      clk_pulse(rnd ? int'($urandom_range(F, F + 4)) : F + 1);
      chk("shift_data", 8'(jp.jp_data_out), 8'(pin_at(r, k)));
      chk("shift_cnt", 8'((k < 8) ? k : 8), 8'(jp.shift_cnt_out));
    end
  endtask

  initial begin
    logic [7:0] r, b;
    logic [1:0] te;
    int s0;
    logic [7:0] turbo_pat;
    jp.btn_in = 8'hFF; jp.turbo_en_in = 2'b00;
    jp.jp_latch_in = 1'b0; jp.jp_clk_in = 1'b0;

    // reset held 3 cycles with all buttons pressed
    apply_reset(3);
    chk("idle_data", 8'(jp.jp_data_out), 8'd1);

    // full poll, with the first shift checked for exact latency
    do_poll(8'h09, 2'b00, 8, r);
    tick(1); jp.jp_clk_in = 1'b1;
    repeat (S + F + 1) @(negedge clk_in);
    chk("lat_pre_data", 8'(jp.jp_data_out), 8'(pin_at(r, 0)));
    chk("lat_pre_cnt", 8'(jp.shift_cnt_out), 8'd0);
    @(negedge clk_in);
    chk("lat_post_data", 8'(jp.jp_data_out), 8'(pin_at(r, 1)));
    chk("lat_post_cnt", 8'(jp.shift_cnt_out), 8'd1);
    tick(1); jp.jp_clk_in = 1'b0; tick(GAP); @(negedge clk_in);
    read_bits(r, 2, 8, 1'b0);

    // overread: bits past 8 read logical 1
    do_poll(8'h00, 2'b00, 6, r);
    read_bits(r, 1, 12, 1'b0);

    // glitches: short clk pulse and short latch pulse mid-read are dropped
    b = 8'($urandom);
    do_poll(b, 2'b00, 5, r);
    read_bits(r, 1, 3, 1'b1);
    clk_pulse(F - 2);
    chk("glitch_clk_cnt", 8'(jp.shift_cnt_out), 8'd3);
    chk("glitch_clk_data", 8'(jp.jp_data_out), 8'(pin_at(r, 3)));
    jp.btn_in = ~b;
    s0 = strobes;
    latch_pulse(F - 1);
    chk("glitch_lat_cnt", 8'(jp.shift_cnt_out), 8'd3);
    chk("glitch_lat_data", 8'(jp.jp_data_out), 8'(pin_at(r, 3)));
    chk("glitch_lat_strobe", 8'(strobes - s0), 8'd0);
    read_bits(r, 4, 8, 1'b1);

    // turbo on A, A held, 8 polls from a fresh reset
    apply_reset(2);
    turbo_pat = 8'b1100_1100;
    for (int p = 0; p < 8; p++) begin
      do_poll(8'h01, 2'b01, 6, r);
      chk("turbo_a", 8'(jp.jp_data_out), 8'(turbo_pat[p] ^ 1'(DAL)));
    end

    // random polls; buttons change during the read and must not leak in
    for (int p = 0; p < 6; p++) begin
      b  = 8'($urandom);
      te = 2'($urandom_range(0, 3));
      do_poll(b, te, int'($urandom_range(F, F + 4)), r);
      jp.btn_in = 8'($urandom);
      jp.turbo_en_in = 2'($urandom_range(0, 3));
      read_bits(r, 1, 8 + int'($urandom_range(0, 2)), 1'b1);
    end

    // latch rise and clk rise together: no shift
    jp.btn_in = 8'hA5; jp.turbo_en_in = 2'b00;
    tick(1); jp.jp_latch_in = 1'b1; jp.jp_clk_in = 1'b1;
    tick(10); jp.jp_clk_in = 1'b0;
    tick(GAP); @(negedge clk_in);
    chk("coll_rise_cnt", 8'(jp.shift_cnt_out), 8'd0);
    // latch fall and clk rise together: fall taken, clk discarded
    s0 = strobes;
    tick(1); jp.jp_latch_in = 1'b0; jp.jp_clk_in = 1'b1;
    r = report(8'hA5, 2'b00, polls);
    polls++;
    tick(GAP); @(negedge clk_in);
    chk("coll_fall_cnt", 8'(jp.shift_cnt_out), 8'd0);
    chk("coll_fall_data", 8'(jp.jp_data_out), 8'(pin_at(r, 0)));
    chk("coll_fall_strobe", 8'(strobes - s0), 8'd1);
    tick(1); jp.jp_clk_in = 1'b0; tick(GAP); @(negedge clk_in);
    read_bits(r, 1, 2, 1'b0);

    // reset mid-shift
    do_poll(8'hFF, 2'b00, 5, r);
    read_bits(r, 1, 3, 1'b0);
    apply_reset(1);
    chk("post_rst_cnt", 8'(jp.shift_cnt_out), 8'd0);
    chk("post_rst_data", 8'(jp.jp_data_out), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
